layer_prior_resolver: RTL and testbench

- Pipelined, parametrised successor to the per-dot combinational palette-source selector in the pixel mixer.
- Resolves main and sub screen in one instance: applies window masks, decodes opacity per mode/bpp, picks the winning layer from the per-mode priority table, and forms the CGRAM index.
- Sits between the BG/OBJ pixel fetchers and colour math; advances on the dot clock-enable with a valid sideband.

---
 rtl/layer_prior_resolver_pkg.sv | 54 +++++
 rtl/layer_prior_resolver_if.sv | 49 ++++
 rtl/layer_prior_resolver_prior_screen_resolve.sv | 134 +++++++++++++
 rtl/layer_prior_resolver.sv | 146 ++++++++++++++
 tb/tb_layer_prior_resolver.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/layer_prior_resolver_pkg.sv
// Shared types, priority slot tables and bit-depth decode for the layer priority resolver.
package layer_prior_resolver_pkg;

   localparam int MAX_BG             = 4;
   localparam int SLOTS              = 12;
   localparam int OBJ_BASE           = 128;
   localparam int MODE0_LAYER_STRIDE = 32;

   typedef enum logic [3:0] {
      BACK, OBJ,
      BG1_2_0, BG2_2_0, BG3_2_0, BG4_2_0,
      BG1_2, BG2_2, BG3_2,
      BG1_4, BG2_4,
      BG1_8, BG2_7
   } refer_pal_type;

   typedef enum logic [3:0] {
      SLOT_NONE,
      BG1_H, BG1_L, BG2_H, BG2_L, BG3_H, BG3_L, BG4_H, BG4_L,
      OBJ_0, OBJ_1, OBJ_2, OBJ_3
   } prior_slot_type;

   // Highest priority first. Merged OBJ slots (O3|O2) are listed back to back,
   // which is equivalent because OBJ has a single priority per dot.
   // Mode 1 entry 0 is the BG3 promote slot, live only when bg3_prior is set.
   localparam prior_slot_type PRIOR_TAB [8][SLOTS] = '{
      '{OBJ_3, BG1_H, BG2_H, OBJ_2, BG1_L, BG2_L, OBJ_1, BG3_H, BG4_H, OBJ_0, BG3_L, BG4_L},
      '{BG3_H, OBJ_3, BG1_H, BG2_H, OBJ_2, BG1_L, BG2_L, OBJ_1, BG3_H, OBJ_0, BG3_L, SLOT_NONE},
      '{OBJ_3, BG1_H, OBJ_2, BG2_H, OBJ_1, BG1_L, OBJ_0, BG2_L, SLOT_NONE, SLOT_NONE, SLOT_NONE, SLOT_NONE},
      '{OBJ_3, BG1_H, OBJ_2, BG2_H, OBJ_1, BG1_L, OBJ_0, BG2_L, SLOT_NONE, SLOT_NONE, SLOT_NONE, SLOT_NONE},
      '{OBJ_3, BG1_H, OBJ_2, BG2_H, OBJ_1, BG1_L, OBJ_0, BG2_L, SLOT_NONE, SLOT_NONE, SLOT_NONE, SLOT_NONE},
      '{OBJ_3, BG1_H, OBJ_2, BG2_H, OBJ_1, BG1_L, OBJ_0, BG2_L, SLOT_NONE, SLOT_NONE, SLOT_NONE, SLOT_NONE},
      '{OBJ_3, BG1_H, OBJ_2, OBJ_1, BG1_L, OBJ_0, SLOT_NONE, SLOT_NONE, SLOT_NONE, SLOT_NONE, SLOT_NONE, SLOT_NONE},
      '{OBJ_3, OBJ_2, BG2_H, OBJ_1, BG1_L, OBJ_0, BG2_L, SLOT_NONE, SLOT_NONE, SLOT_NONE, SLOT_NONE, SLOT_NONE}
   };

   // Colour bits per layer for a mode; 0 = layer absent, 7 = mode 7 EXTBG.
   function automatic logic [3:0] bpp_of(input logic [2:0] mode, input int layer);
      logic [3:0] b;
      b = 4'd0;
      case (mode)
         3'd0:    b = (layer < 4) ? 4'd2 : 4'd0;
         3'd1:    b = (layer < 2) ? 4'd4 : ((layer == 2) ? 4'd2 : 4'd0);
         3'd2:    b = (layer < 2) ? 4'd4 : 4'd0;
         3'd3:    b = (layer == 0) ? 4'd8 : ((layer == 1) ? 4'd4 : 4'd0);
         3'd4:    b = (layer == 0) ? 4'd8 : ((layer == 1) ? 4'd2 : 4'd0);
         3'd5:    b = (layer == 0) ? 4'd4 : ((layer == 1) ? 4'd2 : 4'd0);
         3'd6:    b = (layer == 0) ? 4'd4 : 4'd0;
         default: b = (layer == 0) ? 4'd8 : ((layer == 1) ? 4'd7 : 4'd0);
      endcase
      return b;
   endfunction

endpackage

// File: rtl/layer_prior_resolver_if.sv
// Pixel bus into the resolver and resolved palette source out of it.
// Handshake: a pixel is taken when dot_ce && in_valid on a rising clk edge; out_valid
// marks a result for one advancing cycle and there is no backpressure.
interface layer_prior_resolver_if #(
   parameter int NUM_BG = 4,
   parameter int BPP_W  = 8,
   parameter int CG_W   = 8
);
   import layer_prior_resolver_pkg::*;

   logic                             dot_ce;
   logic                             in_valid;
   logic [2:0]                       bgmode;
   logic                             bg3_prior;
   logic                             use_direct_color;
   logic [NUM_BG:0]                  main_enable;
   logic [NUM_BG:0]                  sub_enable;
   logic [NUM_BG:0]                  main_win;
   logic [NUM_BG:0]                  sub_win;
   logic [NUM_BG-1:0][BPP_W-1:0]     bg_main;
   logic [NUM_BG-1:0][BPP_W-1:0]     bg_sub;
   logic [NUM_BG-1:0]                bg_prior;
   logic [NUM_BG-1:0][2:0]           bg_palette;
   logic [3:0]                       obj_color;
   logic [1:0]                       obj_prior;
   logic [2:0]                       obj_palette;
   logic                             out_valid;
   refer_pal_type                    main_sel;
   refer_pal_type                    sub_sel;
   logic [CG_W-1:0]                  main_idx;
   logic [CG_W-1:0]                  sub_idx;
   logic                             main_direct;
   logic                             sub_direct;

   modport master (
      output dot_ce, in_valid, bgmode, bg3_prior, use_direct_color,
             main_enable, sub_enable, main_win, sub_win, bg_main, bg_sub,
             bg_prior, bg_palette, obj_color, obj_prior, obj_palette,
      input  out_valid, main_sel, sub_sel, main_idx, sub_idx, main_direct, sub_direct
   );

   modport slave (
      input  dot_ce, in_valid, bgmode, bg3_prior, use_direct_color,
             main_enable, sub_enable, main_win, sub_win, bg_main, bg_sub,
             bg_prior, bg_palette, obj_color, obj_prior, obj_palette,
      output out_valid, main_sel, sub_sel, main_idx, sub_idx, main_direct, sub_direct
   );

endinterface

// File: rtl/layer_prior_resolver_prior_screen_resolve.sv
// Second stage for one screen: first-opaque slot scan, winner decode and CGRAM index.
module prior_screen_resolve
   import layer_prior_resolver_pkg::*;
#(
   parameter int BPP_W = 8,
   parameter int CG_W  = 8
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          advance_i,
   input  logic [2:0]                    mode_i,
   input  logic                          bg3_prior_i,
   input  logic                          use_direct_i,
   input  logic [MAX_BG:0]               opq_i,
   input  logic [MAX_BG-1:0]             prior_i,
   input  logic [MAX_BG-1:0][BPP_W-1:0]  col_i,
   input  logic [MAX_BG-1:0][2:0]        pal_i,
   input  logic [3:0]                    obj_col_i,
   input  logic [1:0]                    obj_prior_i,
   input  logic [2:0]                    obj_pal_i,
   output refer_pal_type                 sel_o,
   output logic [CG_W-1:0]               idx_o,
   output logic                          direct_o
);

   prior_slot_type  win;
   refer_pal_type   sel_d, sel_q;
   logic [15:0]     idx_w;
   logic [CG_W-1:0] idx_q;
   logic            direct_d, direct_q;

   always_comb begin
      prior_slot_type slot;
      logic           hit;
      logic           found;
      win   = SLOT_NONE;
      found = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
         slot = PRIOR_TAB[mode_i][i];
         case (slot)
            BG1_H:   hit = opq_i[0] &  prior_i[0];
            BG1_L:   hit = opq_i[0] & ~prior_i[0];
            BG2_H:   hit = opq_i[1] &  prior_i[1];
            BG2_L:   hit = opq_i[1] & ~prior_i[1];
            BG3_H:   hit = opq_i[2] &  prior_i[2];
            BG3_L:   hit = opq_i[2] & ~prior_i[2];
            BG4_H:   hit = opq_i[3] &  prior_i[3];
            BG4_L:   hit = opq_i[3] & ~prior_i[3];
            OBJ_0:   hit = opq_i[MAX_BG] & (obj_prior_i == 2'd0);
            OBJ_1:   hit = opq_i[MAX_BG] & (obj_prior_i == 2'd1);
            OBJ_2:   hit = opq_i[MAX_BG] & (obj_prior_i == 2'd2);
            OBJ_3:   hit = opq_i[MAX_BG] & (obj_prior_i == 2'd3);
            default: hit = 1'b0;
         endcase
         if (i == 0 && mode_i == 3'd1 && !bg3_prior_i) hit = 1'b0;
         if (!found && hit) begin
            found = 1'b1;
            win   = slot;
         end
      end
   end

   always_comb begin
      logic             is_bg;
      logic [1:0]       layer;
      logic [3:0]       bpp;
      logic [BPP_W-1:0] c;
      logic [2:0]       p;
      sel_d    = BACK;
      idx_w    = 16'd0;
      direct_d = 1'b0;
      is_bg    = 1'b1;
      layer    = 2'd0;
      case (win)
         BG1_H, BG1_L: layer = 2'd0;
         BG2_H, BG2_L: layer = 2'd1;
         BG3_H, BG3_L: layer = 2'd2;
         BG4_H, BG4_L: layer = 2'd3;
         default:      is_bg = 1'b0;
      endcase
      bpp = bpp_of(mode_i, int'(layer));
      c   = col_i[layer];
      p   = pal_i[layer];
      if (win inside {OBJ_0, OBJ_1, OBJ_2, OBJ_3}) begin
         sel_d = OBJ;
         idx_w = 16'(OBJ_BASE) + {9'd0, obj_pal_i, 4'd0} + {12'd0, obj_col_i};
      end else if (is_bg && mode_i == 3'd0) begin
         case (layer)
            2'd0:    sel_d = BG1_2_0;
            2'd1:    sel_d = BG2_2_0;
            2'd2:    sel_d = BG3_2_0;
            default: sel_d = BG4_2_0;
         endcase
         idx_w = 16'(layer) * 16'(MODE0_LAYER_STRIDE) + {11'd0, p, 2'b00} + {14'd0, c[1:0]};
      end else if (is_bg) begin
         case (bpp)
            4'd2: begin
               sel_d = (layer == 2'd0) ? BG1_2 : ((layer == 2'd1) ? BG2_2 : BG3_2);
               idx_w = {11'd0, p, 2'b00} + {14'd0, c[1:0]};
            end
            4'd4: begin
               sel_d = (layer == 2'd0) ? BG1_4 : BG2_4;
               idx_w = {9'd0, p, 4'd0} + {12'd0, c[3:0]};
            end
            4'd7: begin
               sel_d = BG2_7;
               idx_w = 16'(c);
            end
            default: begin
               sel_d    = BG1_8;
               idx_w    = 16'(c);
               direct_d = use_direct_i;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sel_q    <= BACK;
         idx_q    <= '0;
         direct_q <= 1'b0;
      end else if (advance_i) begin
         sel_q    <= sel_d;
         idx_q    <= idx_w[CG_W-1:0];
         direct_q <= direct_d;
      end
   end

   assign sel_o    = sel_q;
   assign idx_o    = idx_q;
   assign direct_o = direct_q;

endmodule

// File: rtl/layer_prior_resolver.sv
// Two-stage main/sub palette source resolver: S1 opacity decode, S2 priority resolve and index.
module layer_prior_resolver
   import layer_prior_resolver_pkg::*;
#(
   parameter int NUM_BG = 4,
   parameter int BPP_W  = 8,
   parameter int CG_W   = 8
) (
   input logic                  clk,
   input logic                  reset_n,
   layer_prior_resolver_if.slave bus
);

   logic [MAX_BG:0]               opq_main_d, opq_sub_d, opq_main_q, opq_sub_q;
   logic [MAX_BG-1:0]             prior_main_d, prior_sub_d, prior_main_q, prior_sub_q;
   logic [MAX_BG-1:0][BPP_W-1:0]  col_main_d, col_sub_d, col_main_q, col_sub_q;
   logic [MAX_BG-1:0][2:0]        pal_d, pal_q;
   logic                          s1_valid_q, bg3_prior_q, use_direct_q, out_valid_q;
   logic [2:0]                    mode_q;
   logic [3:0]                    obj_col_q;
   logic [1:0]                    obj_prior_q;
   logic [2:0]                    obj_pal_q;
   logic                          s2_advance;

   // Layers beyond NUM_BG read as fully transparent so S2 always sees four BG slots.
   for (genvar l = 0; l < MAX_BG; l++) begin : g_layer
      if (l < NUM_BG) begin : g_present
         logic [3:0]       bpp;
         logic [BPP_W-1:0] mask;
         logic             direct_ok;

         assign bpp = bpp_of(bus.bgmode, l);

         always_comb begin
            mask = '0;
            for (int b = 0; b < BPP_W; b++) mask[b] = (b < int'(bpp));
         end

         assign direct_ok = (l == 0) && (bpp == 4'd8) && bus.use_direct_color &&
                            (bus.bg_palette[l] != 3'd0);
         assign col_main_d[l] = bus.bg_main[l] & mask;
         assign col_sub_d[l]  = bus.bg_sub[l] & mask;
         assign opq_main_d[l] = bus.main_enable[l] & ~bus.main_win[l] &
                                ((col_main_d[l] != '0) | direct_ok);
         assign opq_sub_d[l]  = bus.sub_enable[l] & ~bus.sub_win[l] &
                                ((col_sub_d[l] != '0) | direct_ok);
         // Mode 7: BG1 has no priority, BG2 takes it from its own colour MSB.
         assign prior_main_d[l] = (bus.bgmode == 3'd7) ? ((l == 1) & bus.bg_main[l][BPP_W-1])
                                                       : bus.bg_prior[l];
         assign prior_sub_d[l]  = (bus.bgmode == 3'd7) ? ((l == 1) & bus.bg_sub[l][BPP_W-1])
                                                       : bus.bg_prior[l];
         assign pal_d[l] = bus.bg_palette[l];
      end else begin : g_absent
         assign col_main_d[l]   = '0;
         assign col_sub_d[l]    = '0;
         assign opq_main_d[l]   = 1'b0;
         assign opq_sub_d[l]    = 1'b0;
         assign prior_main_d[l] = 1'b0;
         assign prior_sub_d[l]  = 1'b0;
         assign pal_d[l]        = 3'd0;
      end
   end

   assign opq_main_d[MAX_BG] = bus.main_enable[NUM_BG] & ~bus.main_win[NUM_BG] & (bus.obj_color != 4'd0);
   assign opq_sub_d[MAX_BG]  = bus.sub_enable[NUM_BG] & ~bus.sub_win[NUM_BG] & (bus.obj_color != 4'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q   <= 1'b0;
         mode_q       <= 3'd0;
         bg3_prior_q  <= 1'b0;
         use_direct_q <= 1'b0;
         opq_main_q   <= '0;
         opq_sub_q    <= '0;
         prior_main_q <= '0;
         prior_sub_q  <= '0;
         col_main_q   <= '0;
         col_sub_q    <= '0;
         pal_q        <= '0;
         obj_col_q    <= 4'd0;
         obj_prior_q  <= 2'd0;
         obj_pal_q    <= 3'd0;
         out_valid_q  <= 1'b0;
      end else if (bus.dot_ce) begin
         s1_valid_q   <= bus.in_valid;
         mode_q       <= bus.bgmode;
         bg3_prior_q  <= bus.bg3_prior;
         use_direct_q <= bus.use_direct_color;
         opq_main_q   <= opq_main_d;
         opq_sub_q    <= opq_sub_d;
         prior_main_q <= prior_main_d;
         prior_sub_q  <= prior_sub_d;
         col_main_q   <= col_main_d;
         col_sub_q    <= col_sub_d;
         pal_q        <= pal_d;
         obj_col_q    <= bus.obj_color;
         obj_prior_q  <= bus.obj_prior;
         obj_pal_q    <= bus.obj_palette;
         out_valid_q  <= s1_valid_q;
      end
   end

   // Bubbles leave the result registers untouched.
   assign s2_advance = bus.dot_ce & s1_valid_q;

   prior_screen_resolve #(.BPP_W(BPP_W), .CG_W(CG_W)) u_main (
      .clk         (clk),
      .reset_n     (reset_n),
      .advance_i   (s2_advance),
      .mode_i      (mode_q),
      .bg3_prior_i (bg3_prior_q),
      .use_direct_i(use_direct_q),
      .opq_i       (opq_main_q),
      .prior_i     (prior_main_q),
      .col_i       (col_main_q),
      .pal_i       (pal_q),
      .obj_col_i   (obj_col_q),
      .obj_prior_i (obj_prior_q),
      .obj_pal_i   (obj_pal_q),
      .sel_o       (bus.main_sel),
      .idx_o       (bus.main_idx),
      .direct_o    (bus.main_direct)
   );

   prior_screen_resolve #(.BPP_W(BPP_W), .CG_W(CG_W)) u_sub (
      .clk         (clk),
      .reset_n     (reset_n),
      .advance_i   (s2_advance),
      .mode_i      (mode_q),
      .bg3_prior_i (bg3_prior_q),
      .use_direct_i(use_direct_q),
      .opq_i       (opq_sub_q),
      .prior_i     (prior_sub_q),
      .col_i       (col_sub_q),
      .pal_i       (pal_q),
      .obj_col_i   (obj_col_q),
      .obj_prior_i (obj_prior_q),
      .obj_pal_i   (obj_pal_q),
      .sel_o       (bus.sub_sel),
      .idx_o       (bus.sub_idx),
      .direct_o    (bus.sub_direct)
   );

   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_layer_prior_resolver.sv
// Directed bench for layer_prior_resolver: hand-computed palette sources and CGRAM indices.
module tb_layer_prior_resolver;
   import layer_prior_resolver_pkg::*;

   logic clk;
   logic reset_n;
   int   n_vec;
   int   n_miss;

   layer_prior_resolver_if #(.NUM_BG(4), .BPP_W(8), .CG_W(8)) bus ();

   layer_prior_resolver #(.NUM_BG(4), .BPP_W(8), .CG_W(8)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_miss++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_main(input string tag, input refer_pal_type sel, input logic [7:0] idx,
                              input logic dir);
      check({tag, ".main_sel"}, 32'(bus.main_sel), 32'(sel));
      check({tag, ".main_idx"}, 32'(bus.main_idx), 32'(idx));
      check({tag, ".main_direct"}, 32'(bus.main_direct), 32'(dir));
   endtask

   task automatic expect_sub(input string tag, input refer_pal_type sel, input logic [7:0] idx,
                             input logic dir);
      check({tag, ".sub_sel"}, 32'(bus.sub_sel), 32'(sel));
      check({tag, ".sub_idx"}, 32'(bus.sub_idx), 32'(idx));
      check({tag, ".sub_direct"}, 32'(bus.sub_direct), 32'(dir));
   endtask

   task automatic clear_pixel();
      bus.bgmode           = 3'd0;
      bus.bg3_prior        = 1'b0;
      bus.use_direct_color = 1'b0;
      bus.main_enable      = 5'h1F;
      bus.sub_enable       = 5'h1F;
      bus.main_win         = 5'h00;
      bus.sub_win          = 5'h00;
      bus.bg_main          = '0;
      bus.bg_sub           = '0;
      bus.bg_prior         = '0;
      bus.bg_palette       = '0;
      bus.obj_color        = 4'd0;
      bus.obj_prior        = 2'd0;
      bus.obj_palette      = 3'd0;
   endtask

   // One valid dot followed by one bubble: the result is on the outputs afterwards.
   task automatic run_pixel();
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
   endtask

   initial begin
      n_vec        = 0;
      n_miss       = 0;
      reset_n      = 1'b0;
      bus.dot_ce   = 1'b1;
      bus.in_valid = 1'b0;
      clear_pixel();
      step();
      step();

      check("reset.out_valid", 32'(bus.out_valid), 32'd0);
      expect_main("reset", BACK, 8'h00, 1'b0);
      expect_sub("reset", BACK, 8'h00, 1'b0);
      #2 reset_n = 1'b1;
      step();

      // Mode 0, everything transparent.
      run_pixel();
      check("m0_empty.out_valid", 32'(bus.out_valid), 32'd1);
      expect_main("m0_empty", BACK, 8'h00, 1'b0);
      expect_sub("m0_empty", BACK, 8'h00, 1'b0);

      // Mode 0: BG2 high beats OBJ prio 2 on main; sub only has OBJ.
      clear_pixel();
      bus.bg_main[1]    = 8'd2;
      bus.bg_palette[1] = 3'd3;
      bus.bg_prior[1]   = 1'b1;
      bus.obj_color     = 4'd5;
      bus.obj_prior     = 2'd2;
      run_pixel();
      check("m0_bg2.out_valid", 32'(bus.out_valid), 32'd1);
      expect_main("m0_bg2", BG2_2_0, 8'h2E, 1'b0);
      expect_sub("m0_bg2", OBJ, 8'h85, 1'b0);
      step();
      check("bubble.out_valid", 32'(bus.out_valid), 32'd0);
      check("bubble.main_idx_held", 32'(bus.main_idx), 32'h2E);

      // Mode 1 with BG3 promote; sub has BG3 disabled.
      clear_pixel();
      bus.bgmode        = 3'd1;
      bus.bg3_prior     = 1'b1;
      bus.bg_main[2]    = 8'd1;
      bus.bg_sub[2]     = 8'd1;
      bus.bg_prior[2]   = 1'b1;
      bus.sub_enable    = 5'b11011;
      bus.obj_color     = 4'd4;
      bus.obj_prior     = 2'd3;
      bus.obj_palette   = 3'd1;
      run_pixel();
      expect_main("m1_promote", BG3_2, 8'h01, 1'b0);
      expect_sub("m1_promote", OBJ, 8'h94, 1'b0);
      bus.bg3_prior = 1'b0;
      run_pixel();
      expect_main("m1_nopromote", OBJ, 8'h94, 1'b0);

      // Mode 3: direct-colour BG1 with colour 0 is opaque through its palette.
      clear_pixel();
      bus.bgmode           = 3'd3;
      bus.use_direct_color = 1'b1;
      bus.bg_palette[0]    = 3'd2;
      bus.bg_main[1]       = 8'd5;
      bus.bg_palette[1]    = 3'd1;
      run_pixel();
      expect_main("m3_direct", BG1_8, 8'h00, 1'b1);
      expect_sub("m3_direct", BG1_8, 8'h00, 1'b1);
      bus.main_win = 5'b00001;
      run_pixel();
      expect_main("m3_win", BG2_4, 8'h15, 1'b0);
      check("m3_win.sub_sel", 32'(bus.sub_sel), 32'(BG1_8));

      // Mode 7: EXTBG BG2 priority from colour bit 7, index uses colour[6:0].
      clear_pixel();
      bus.bgmode     = 3'd7;
      bus.bg_main[0] = 8'h10;
      bus.bg_main[1] = 8'h85;
      bus.bg_sub[0]  = 8'h10;
      bus.bg_sub[1]  = 8'h05;
      run_pixel();
      expect_main("m7_extbg", BG2_7, 8'h05, 1'b0);
      expect_sub("m7_extbg", BG1_8, 8'h10, 1'b0);

      // Stall: pixel A, bubble, pixel B with dot_ce low for 3 cycles after A emerges.
      clear_pixel();
      bus.bg_main[0]    = 8'd3;
      bus.bg_palette[0] = 3'd1;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      check("stall_a.out_valid", 32'(bus.out_valid), 32'd1);
      check("stall_a.main_idx", 32'(bus.main_idx), 32'h07);
      clear_pixel();
      bus.bg_main[3]    = 8'd1;
      bus.bg_palette[3] = 3'd2;
      bus.dot_ce   = 1'b0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_hold.out_valid", 32'(bus.out_valid), 32'd1);
         check("stall_hold.main_idx", 32'(bus.main_idx), 32'h07);
      end
      bus.dot_ce = 1'b1;
      step();
      check("stall_gap.out_valid", 32'(bus.out_valid), 32'd0);
      check("stall_gap.main_idx", 32'(bus.main_idx), 32'h07);
      bus.in_valid = 1'b0;
      step();
      check("stall_b.out_valid", 32'(bus.out_valid), 32'd1);
      expect_main("stall_b", BG4_2_0, 8'h69, 1'b0);
      step();
      check("stall_end.out_valid", 32'(bus.out_valid), 32'd0);

      // Reset with two pixels in flight, then a fresh pixel after release.
      clear_pixel();
      bus.bg_main[0]    = 8'd3;
      bus.bg_palette[0] = 3'd1;
      bus.in_valid = 1'b1;
      step();
      bus.bg_main[3]    = 8'd1;
      bus.bg_palette[3] = 3'd2;
      step();
      check("flight.out_valid", 32'(bus.out_valid), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst.out_valid", 32'(bus.out_valid), 32'd0);
      check("async_rst.main_sel", 32'(bus.main_sel), 32'(BACK));
      check("async_rst.main_idx", 32'(bus.main_idx), 32'h00);
      bus.in_valid = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      clear_pixel();
      bus.bg_main[2]    = 8'd2;
      bus.bg_palette[2] = 3'd1;
      bus.bg_prior[2]   = 1'b1;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      check("post_rst_first.out_valid", 32'(bus.out_valid), 32'd0);
      step();
      check("post_rst_e.out_valid", 32'(bus.out_valid), 32'd1);
      expect_main("post_rst_e", BG3_2_0, 8'h46, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
